alu_serial_seq: RTL and testbench

//  Bit-serial N-bit ALU sequencer; drives one alu1bit slice LSB->MSB, one bit per clk.
//  - Accepts an operand pair + opcode on a valid/ready input handshake.
//  - Feeds the slice its carry through a registered loop and assembles the N-bit result.
//  - Returns the result on a valid/ready output handshake.
//  - Sits as the initiator of the alu1bit slice interface (a, b, cin, op -> s, cout).

---
 rtl/alu_serial_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_serial_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial N-bit ALU sequencer: feeds a one-bit NOR/XOR/ADD/SUB slice LSB first, one bit per clock.
// Define ALU_SERIAL_OVF_EN to add the signed-overflow output out_ovf.
module alu_serial_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s,
  output logic         out_cout
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [1:0]    OP_SUB   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_res;
  logic [1:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_cout;
  logic          w_accept;
  logic          w_last;
  logic          w_arith;
  logic          w_s;
  logic          w_cout;
  logic [1:0]    w_slice;
`ifdef ALU_SERIAL_OVF_EN
  logic          r_out_ovf;
`endif

  // One-bit slice, returns {cout, s}; SUB inverts b and relies on the carry loop starting at 1.
  function automatic logic [1:0] alu1bit(input logic a, input logic b, input logic cin,
                                         input logic [1:0] op);
    logic       bx;
    logic [1:0] r;
    bx = b ^ op[0];
    case (op)
      2'b00:        r = {1'b0, ~(a | b)};
      2'b01:        r = {1'b0, a ^ b};
      2'b10, 2'b11: r = {(a & bx) | (a & cin) | (bx & cin), a ^ bx ^ cin};
      default:      r = 2'b00;
    endcase
    return r;
  endfunction

  // Next-state decode and the slice evaluation for the current bit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_cnt == LAST_BIT);
    w_arith     = r_op[1];
    w_slice     = alu1bit(r_a[r_cnt], r_b[r_cnt], r_carry, r_op);
    w_s         = w_slice[0];
    w_cout      = w_slice[1];
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, operand latch, carry loop and result assembly; handshake flags track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= {N{1'b0}};
      r_b         <= {N{1'b0}};
      r_res       <= {N{1'b0}};
      r_op        <= 2'b00;
      r_cnt       <= {CW{1'b0}};
      r_carry     <= 1'b0;
      r_out_cout  <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      r_out_ovf   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_op    <= in_op;
            r_cnt   <= {CW{1'b0}};
            r_carry <= (in_op == OP_SUB);
          end
        end
        ST_RUN: begin
          r_res[r_cnt] <= w_s;
          r_carry      <= w_cout;
          if (w_last) begin
            r_out_cout <= w_arith & w_cout;
`ifdef ALU_SERIAL_OVF_EN
            // r_carry still holds the carry into the MSB during this last bit.
            r_out_ovf  <= w_arith & (r_carry ^ w_cout);
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_s     = r_res;
  assign out_cout  = r_out_cout;
`ifdef ALU_SERIAL_OVF_EN
  assign out_ovf   = r_out_ovf;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (N=8): directed table, backpressure, reset abort, random ops.
module tb_alu_serial_seq;
  localparam int     N    = 8;
  localparam longint UMAX = (longint'(1) << N) - 1;
  localparam longint SMAX = (longint'(1) << (N - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (N - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_s;
  logic         out_cout;
`ifdef ALU_SERIAL_OVF_EN
  logic         out_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [10];

  alu_serial_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout)
`ifdef ALU_SERIAL_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference result {ovf, cout, s} from unsigned/signed integer arithmetic.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [1:0] op);
    longint       ua, ub, sa, sb, r;
    logic [N-1:0] s;
    logic         c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      2'b00: s = ~(a | b);
      2'b01: s = a ^ b;
      2'b10: begin
        s = N'(ua + ub);
        c = (ua + ub) > UMAX;
        r = sa + sb;
        v = (r > SMAX) || (r < SMIN);
      end
      default: begin
        s = N'(ua - ub);
        c = (ua >= ub);
        r = sa - sb;
        v = (r > SMAX) || (r < SMIN);
      end
    endcase
    return {v, c, s};
  endfunction

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op,
                       input logic [N-1:0] es, input logic ec, input logic ev,
                       input int hold, input bit scramble, input bit early, input bit keep_valid,
                       input string tag);
    int cyc;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    out_ready = early;
    cyc = 1;
    for (int i = 0; i < 4 * N; i++) begin
      if (out_valid) break;
      check({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
      if (scramble) begin
        in_a  = N'($urandom);
        in_b  = N'($urandom);
        in_op = 2'($urandom_range(3, 0));
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(N + 1));
    check({tag, " out_s"}, 32'(out_s), 32'(es));
    check({tag, " out_cout"}, 32'(out_cout), 32'(ec));
`ifdef ALU_SERIAL_OVF_EN
    check({tag, " out_ovf"}, 32'(out_ovf), 32'(ev));
`endif
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check({tag, " hold valid"}, 32'(out_valid), 32'd1);
        check({tag, " hold s"}, 32'(out_s), 32'(es));
        check({tag, " hold cout"}, 32'(out_cout), 32'(ec));
        check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post valid"}, 32'(out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] a, b, es;
    logic [1:0]   op;
    logic         ec, ev;
    int           hold;
    bit           early;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;

    vecs[0] = '{8'h7F, 8'h01, 2'b10, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'h05, 8'h07, 2'b11, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 8'h05, 2'b11, 8'h02, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 8'hFF, 2'b01, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'h0F, 8'hF0, 2'b00, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, 2'b10, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 2'b11, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 2'b10, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{8'h00, 8'h00, 2'b00, 8'hFF, 1'b0, 1'b0};
    vecs[9] = '{8'h00, 8'h00, 2'b11, 8'h00, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_s", 32'(out_s), 32'd0);
    check("reset out_cout", 32'(out_cout), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
    check("reset out_ovf", 32'(out_ovf), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      hold  = i % 3;
      early = (hold == 0) && (i % 2 == 0);
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].s, vecs[i].cout, vecs[i].ovf,
            hold, (i % 2) == 1, early, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure with a second request pending through DONE, accepted right after the handshake.
    do_op(8'h3C, 8'h0F, 2'b10, 8'h4B, 1'b0, 1'b0, 5, 1'b1, 1'b0, 1'b1, "bp");
    do_op(8'h01, 8'h01, 2'b11, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "bp2");

    for (int i = 0; i < 40; i++) begin
      a  = N'($urandom);
      b  = N'($urandom);
      op = 2'($urandom_range(3, 0));
      {ev, ec, es} = model(a, b, op);
      hold  = int'($urandom_range(3, 0));
      early = (hold == 0) && ($urandom_range(1, 0) == 1);
      do_op(a, b, op, es, ec, ev, hold, $urandom_range(1, 0) == 1, early, 1'b0,
            $sformatf("rnd%0d", i));
    end

    // Reset abort while bit 3 is in flight, after a nonzero result with carry set.
    do_op(8'hFF, 8'h02, 2'b10, 8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "pre_rst");
    in_a     = 8'h10;
    in_b     = 8'h20;
    in_op    = 2'b10;
    in_valid = 1'b1;
    for (int w = 0; w < 50 && !in_ready; w++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_s", 32'(out_s), 32'd0);
    check("abort out_cout", 32'(out_cout), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(8'h10, 8'h20, 2'b10, 8'h30, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
